// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial adder/subtractor. The block reads operand A and then operand B
//   from si, LSB first. It then ripples one full-adder step per clock and
//   presents the N-bit result with its carry out.
//
//   Timeline, counting the edge that accepts start as E0:
//     E1   .. E2N : LOAD, shift si into A (first N bits) and B (next N bits)
//     E2N+1.. E3N : RUN, one sum bit per edge, shifted into A at the MSB
//     E3N         : result/cout registered, done raised for one cycle
//
//   Optional build macro:
//     SERIAL_ADDSUB_OVF_EN : adds output ovf, the signed two's-complement
//                            overflow flag (carry into MSB XOR carry out).
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sub,
    input  logic         si,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    // The counter must reach 2N-1 in LOAD without wrapping.
    localparam int CW = $clog2(2 * N + 1);

    localparam logic [CW-1:0] CNT_N     = CW'(N);
    localparam logic [CW-1:0] LOAD_LAST = CW'(2 * N - 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_mode;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_result;
    logic          r_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic          r_ovf;
`endif

    // One full-adder slice. In subtract mode B is inverted and the carry
    // starts at 1, which gives A + ~B + 1 = A - B.
    logic w_b_eff;
    logic w_sum;
    logic w_carry_out;

    assign w_b_eff     = r_b[0] ^ r_mode;
    assign w_sum       = r_a[0] ^ w_b_eff ^ r_carry;
    assign w_carry_out = (r_a[0] & w_b_eff) | (r_a[0] & r_carry) | (w_b_eff & r_carry);

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf    = r_ovf;
`endif

    // Control FSM and datapath: the state and all registered outputs advance together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_mode   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            // NOTE: every assignment here is non-blocking, so each branch
            // reads the values registered at the previous edge. A blocking
            // '=' would let a later statement see a half-updated shift register.
            case (r_state)
                S_IDLE: begin
                    r_carry <= 1'b0;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                    if (start) begin
                        // sub is captured only here. Later changes on the
                        // pin cannot affect an operation already in flight.
                        r_mode  <= sub;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (r_cnt < CNT_N) begin
                        r_a <= {si, r_a[N-1:1]};
                    end else begin
                        r_b <= {si, r_b[N-1:1]};
                    end

                    if (r_cnt == LOAD_LAST) begin
                        // Seed the carry for two's-complement subtraction.
                        r_carry <= r_mode;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_RUN: begin
                    // Sum bits enter at the MSB. After N steps, A holds the
                    // whole result and B has been shifted out.
                    r_a     <= {w_sum, r_a[N-1:1]};
                    r_b     <= {1'b0, r_b[N-1:1]};
                    r_carry <= w_carry_out;

                    if (r_cnt == RUN_LAST) begin
                        r_result <= {w_sum, r_a[N-1:1]};
                        r_cout   <= w_carry_out;
`ifdef SERIAL_ADDSUB_OVF_EN
                        // r_carry is the carry into the MSB on this last step.
                        r_ovf    <= r_carry ^ w_carry_out;
`endif
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_DONE: begin
                    // start is deliberately ignored here. The earliest
                    // restart is the IDLE edge that follows.
                    r_done  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end

                default: begin
                    // Recovery from a corrupted state register.
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//   Directed test of serial_addsub. Expected values are hand-computed.
//   dut8 (N=8) covers add, subtract, wrap-around, reset abort and ignored
//   start/sub. dut4 (N=4) covers back-to-back operations with start held high.
//   Define SERIAL_ADDSUB_OVF_EN on both compiles to also check ovf.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic       sub8;
    logic       si8;
    logic       busy8;
    logic       done8;
    logic [7:0] result8;
    logic       cout8;

    logic       start4;
    logic       sub4;
    logic       si4;
    logic       busy4;
    logic       done4;
    logic [3:0] result4;
    logic       cout4;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic       ovf8;
    logic       ovf4;
`endif

    int n_checks;
    int n_errors;

    serial_addsub #(.N(8)) dut8 (
        .clk    (clk),
        .reset  (rst_n),
        .start  (start8),
        .sub    (sub8),
        .si     (si8),
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .cout   (cout8)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf    (ovf8)
`endif
    );

    serial_addsub #(.N(4)) dut4 (
        .clk    (clk),
        .reset  (rst_n),
        .start  (start4),
        .sub    (sub4),
        .si     (si4),
        .busy   (busy4),
        .done   (done4),
        .result (result4),
        .cout   (cout4)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf    (ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Full dut8 operation. The task is entered and left at a negedge.
    // toggle_sub flips sub right after E0. pulse_start raises start for one
    // cycle during RUN. Both must leave the result unchanged.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input bit toggle_sub, input bit pulse_start,
                          input logic [7:0] exp_res, input logic exp_cout);
        logic [15:0] stream;
        int          edges;
        int          busy_drop;
        stream    = {b, a};
        busy_drop = 0;

        start8 = 1'b1;
        sub8   = s;
        si8    = 1'b0;
        @(negedge clk);                     // E0 has happened
        start8 = 1'b0;
        if (toggle_sub) sub8 = ~s;
        check({tag, "_busy_e0"}, 32'(busy8), 32'd1);

        for (int i = 0; i < 16; i++) begin
            si8 = stream[i];
            @(negedge clk);                 // edge E(i+1)
            if (busy8 !== 1'b1) busy_drop++;
        end
        si8   = 1'b0;
        edges = 16;

        while (done8 !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
            if (pulse_start) start8 = (edges == 19);
            if (done8 !== 1'b1 && busy8 !== 1'b1) busy_drop++;
        end
        start8 = 1'b0;

        check({tag, "_latency"}, 32'(edges), 32'd24);
        check({tag, "_busy_cont"}, 32'(busy_drop), 32'd0);
        check({tag, "_result"}, 32'(result8), 32'(exp_res));
        check({tag, "_cout"}, 32'(cout8), 32'(exp_cout));
        check({tag, "_busy_done"}, 32'(busy8), 32'd0);

        @(negedge clk);                     // E3N+1: back in IDLE
        check({tag, "_done_pulse"}, 32'(done8), 32'd0);
        check({tag, "_no_restart"}, 32'(busy8), 32'd0);
        sub8 = 1'b0;
    endtask

    initial begin
        logic [15:0] stream;
        logic [7:0]  s1;
        logic [7:0]  s2;
        int          nxt;
        int          bad;

        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; si8 = 1'b0;
        start4 = 1'b0; sub4 = 1'b0; si4 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",   32'(busy8),   32'd0);
        check("rst_done",   32'(done8),   32'd0);
        check("rst_result", 32'(result8), 32'd0);
        check("rst_cout",   32'(cout8),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Add, subtract both ways, wrap-around
        run_op("add_3c_25", 8'h3C, 8'h25, 1'b0, 1'b0, 1'b0, 8'h61, 1'b0);
        run_op("sub_3c_25", 8'h3C, 8'h25, 1'b1, 1'b0, 1'b0, 8'h17, 1'b1);
        run_op("sub_25_3c", 8'h25, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hE9, 1'b0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("sub_25_3c_ovf", 32'(ovf8), 32'd0);
`endif
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("add_7f_01_ovf", 32'(ovf8), 32'd1);
`endif

        // Reset during LOAD bit 5. result is 0x80 at this point.
        stream = {8'h34, 8'h12};
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            si8 = stream[i];
            @(negedge clk);
        end
        si8 = stream[5];
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   32'(busy8),   32'd0);
        check("abort_done",   32'(done8),   32'd0);
        check("abort_result", 32'(result8), 32'd0);
        check("abort_cout",   32'(cout8),   32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("abort_ovf",    32'(ovf8),    32'd0);
`endif
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        si8   = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) bad++;
        end
        check("abort_quiet", 32'(bad), 32'd0);
        run_op("after_abort", 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);

        // start pulsed in RUN and sub flipped after E0. The add must still complete.
        run_op("ignore_evts", 8'h81, 8'h42, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0);

        // dut4: start held high, two operations back to back.
        // Op1 3+5=8 (cout 0), op2 9+9=0x12 -> 2 (cout 1). Op2 starts at E14.
        s1 = {4'h5, 4'h3};
        s2 = {4'h9, 4'h9};
        start4 = 1'b1;
        sub4   = 1'b0;
        si4    = 1'b0;
        for (int e = 0; e <= 26; e++) begin
            @(negedge clk);                 // edge e has happened
            case (e)
                0:  check("b2b_busy_e0",   32'(busy4), 32'd1);
                11: check("b2b_no_done11", 32'(done4), 32'd0);
                12: begin
                    check("b2b_done1",   32'(done4),   32'd1);
                    check("b2b_result1", 32'(result4), 32'd8);
                    check("b2b_cout1",   32'(cout4),   32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
                    check("b2b_ovf1",    32'(ovf4),    32'd1);
`endif
                end
                13: begin
                    check("b2b_done_drop", 32'(done4), 32'd0);
                    check("b2b_idle13",    32'(busy4), 32'd0);
                end
                14: begin
                    check("b2b_accept14", 32'(busy4),   32'd1);
                    check("b2b_hold14",   32'(result4), 32'd8);
                end
                20: check("b2b_hold20", 32'(result4), 32'd8);
                25: begin
                    check("b2b_hold25",   32'(result4), 32'd8);
                    check("b2b_no_done25", 32'(done4),  32'd0);
                end
                26: begin
                    check("b2b_done2",   32'(done4),   32'd1);
                    check("b2b_result2", 32'(result4), 32'd2);
                    check("b2b_cout2",   32'(cout4),   32'd1);
`ifdef SERIAL_ADDSUB_OVF_EN
                    check("b2b_ovf2",    32'(ovf4),    32'd1);
`endif
                end
                default: ;
            endcase
            nxt = e + 1;
            if (nxt >= 1 && nxt <= 8)        si4 = s1[nxt-1];
            else if (nxt >= 15 && nxt <= 22) si4 = s2[nxt-15];
            else                             si4 = 1'b0;
        end
        start4 = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand and result width in bits; legal range 2..32.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single system clock, rising-edge active.
REQ-003 Port reset SHALL be an input, 1 bit wide: an asynchronous, active-low reset.
REQ-004 Port start SHALL be an input, 1 bit wide: an operation request, sampled only in IDLE.
REQ-005 Port sub SHALL be an input, 1 bit wide: mode select (0 = A+B, 1 = A-B), sampled with start.
REQ-006 Port si SHALL be an input, 1 bit wide: the serial operand input, LSB first, A then B.
REQ-007 Port busy SHALL be an output, 1 bit wide: high while in LOAD or RUN.
REQ-008 Port done SHALL be an output, 1 bit wide: a one-cycle completion pulse.
REQ-009 Port result SHALL be an output, N bits wide: the sum or difference, registered.
REQ-010 Port cout SHALL be an output, 1 bit wide: final carry out (for subtraction, 1 = no borrow).

Function
REQ-011 The FSM SHALL have the states IDLE, LOAD, RUN and DONE, and no others; any illegal encoding SHALL go to IDLE.
REQ-012 IDLE SHALL clear the carry and counter, latch sub into an internal mode bit and go to LOAD on the edge where start=1; otherwise it SHALL stay in IDLE.
REQ-013 Call the accepting edge E0; si SHALL be sampled on edges E1..E2N, with the first N bits shifted into A and the next N bits shifted into B, LSB first.
REQ-014 The FSM SHALL go from LOAD to RUN on edge E2N.
REQ-015 RUN SHALL process one bit per edge on E2N+1..E3N: sum = a ^ b' ^ c and c <= maj(a, b', c), where b' = b XOR mode.
REQ-016 The initial carry SHALL be 0 for add and 1 for subtract (two's complement).
REQ-017 Sum bits SHALL shift into A MSB-first so that after N edges A holds the full result.
REQ-018 On edge E3N, result and cout SHALL be updated and the FSM SHALL go to DONE.
REQ-019 done SHALL be 1 only in the cycle between E3N and E3N+1; the FSM SHALL then return to IDLE.
REQ-020 Latency from start acceptance to the done pulse SHALL be 3N edges; minimum start-to-start spacing SHALL be 3N+2 cycles.
REQ-021 result and cout SHALL hold their values from the last completed operation until the next E3N or reset.
REQ-022 start SHALL be ignored in LOAD, RUN and DONE; a start held high SHALL be accepted at the first IDLE edge.
REQ-023 A change on sub after E0 SHALL have no effect on the current operation.
REQ-024 The internal counter SHALL be wide enough to count to 2N without wrapping, and SHALL be cleared at each state transition.
REQ-025 Arithmetic SHALL be modulo 2^N; carry out of the MSB SHALL appear only on cout.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, A=B=0, carry=0, counter=0, busy=0, done=0, result=0, cout=0 (and ovf=0 where present), independent of clk.
REQ-027 A reset asserted mid-LOAD or mid-RUN SHALL abort the operation, with no done pulse and result left at 0.
REQ-028 The first start SHALL be accepted at the first rising edge after reset is released that has start=1.

Configuration
REQ-029 When macro SERIAL_ADDSUB_OVF_EN is defined, the block SHALL have an output ovf, 1 bit wide, updated on E3N to (carry into MSB) XOR (carry out of MSB), giving signed two's-complement overflow, and held like result.
REQ-030 When SERIAL_ADDSUB_OVF_EN is undefined, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Add, N=8: A=0x3C, B=0x25, sub=0 -> result=0x61, cout=0, done high exactly 24 edges after E0.
REQ-032 Subtract, N=8: A=0x3C, B=0x25, sub=1 -> result=0x17, cout=1; and A=0x25, B=0x3C, sub=1 -> result=0xE9, cout=0.
REQ-033 Wrap-around, N=8: A=0xFF, B=0x01, sub=0 -> result=0x00, cout=1; with OVF_EN, A=0x7F, B=0x01 -> result=0x80, ovf=1.
REQ-034 Reset during LOAD bit 5 -> all outputs 0 at once, no done pulse; the next full operation returns the correct result.
REQ-035 start pulsed during RUN, and sub toggled after E0 -> no restart, result unchanged by either event, busy continuous until DONE.
REQ-036 start held high, N=4, with two back-to-back operations -> the second is accepted 3N+2 cycles after the first, and result holds the first value until the second E3N.
